// File: rtl/q_seq_monitor.sv
// q_seq_monitor: checks that sampled q_in advances by STEP each valid sample.
// Reports lock state, mismatch pulses, saturating error and wrap counters.
module q_seq_monitor #(
    parameter int WIDTH    = 5,
    parameter int STEP     = 1,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] q_in,
    input  logic             clear,
    output logic             locked,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(LOCK_CNT - 1);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] wrap_q, wrap_d;

    logic [WIDTH-1:0] expected;
    logic             good;
    logic             lock_hit;

    assign expected = prev_q + STEP_V;
    assign good     = (q_in == expected);
    // Comparing run_q against LOCK_CNT-1 avoids overflow of run_q+1.
    assign lock_hit = (run_q >= LAST_V);

    // Next-state, sequence check and counter updates.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        run_d      = run_q;
        mismatch_d = 1'b0;
        err_d      = err_q;
        wrap_d     = wrap_q;
        if (reset || clear) begin
            state_d = ST_EMPTY;
            prev_d  = '0;
            run_d   = '0;
            err_d   = '0;
            wrap_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (valid) begin
                        prev_d  = q_in;
                        run_d   = '0;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK, ST_LOCK: begin
                    if (valid) begin
                        prev_d = q_in;
                        if (good) begin
                            if (lock_hit) begin
                                run_d   = LOCK_V;
                                state_d = ST_LOCK;
                            end else begin
                                run_d   = run_q + 1'b1;
                                state_d = ST_TRACK;
                            end
                            if (q_in < prev_q) begin
                                wrap_d = wrap_q + 1'b1;
                            end
                        end else begin
                            mismatch_d = 1'b1;
                            run_d      = '0;
                            state_d    = ST_TRACK;
                            if (err_q != '1) begin
                                err_d = err_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        state_q    <= state_d;
        prev_q     <= prev_d;
        run_q      <= run_d;
        mismatch_q <= mismatch_d;
        err_q      <= err_d;
        wrap_q     <= wrap_d;
    end

    assign locked   = (state_q == ST_LOCK);
    assign mismatch = mismatch_q;
    assign err_cnt  = err_q;
    assign wrap_cnt = wrap_q;
    assign state    = state_q;

endmodule

// File: tb/tb_q_seq_monitor.sv
// tb_q_seq_monitor: directed scoreboard bench for q_seq_monitor.
// Expected outputs are queued per step and compared one edge later.
module tb_q_seq_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic [4:0] q_in = '0;
    logic       clear = 1'b0;
    logic       locked;
    logic       mismatch;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic [1:0] state;

    typedef struct {
        logic [1:0] st;
        logic       lk;
        logic       mm;
        logic [7:0] err;
        logic [7:0] wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_step  = 0;

    q_seq_monitor dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .q_in    (q_in),
        .clear   (clear),
        .locked  (locked),
        .mismatch(mismatch),
        .err_cnt (err_cnt),
        .wrap_cnt(wrap_cnt),
        .state   (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: got running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL step%0d %s: got %0d expected %0d",
                   n_step, tag, got, want);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic v,
                        input logic [4:0] q, input logic [1:0] st,
                        input logic lk, input logic mm,
                        input logic [7:0] err, input logic [7:0] wrap);
        exp_t e;
        reset = r;
        clear = c;
        valid = v;
        q_in  = q;
        e.st = st; e.lk = lk; e.mm = mm; e.err = err; e.wrap = wrap;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        n_step++;
        e = exp_q.pop_front();
        chk("state", {6'd0, state}, {6'd0, e.st});
        chk("locked", {7'd0, locked}, {7'd0, e.lk});
        chk("mismatch", {7'd0, mismatch}, {7'd0, e.mm});
        chk("err_cnt", err_cnt, e.err);
        chk("wrap_cnt", wrap_cnt, e.wrap);
    endtask

    task automatic smp(input logic [4:0] q, input logic [1:0] st,
                       input logic lk, input logic mm,
                       input logic [7:0] err, input logic [7:0] wrap);
        step(1'b0, 1'b0, 1'b1, q, st, lk, mm, err, wrap);
    endtask

    task automatic idle(input logic [1:0] st, input logic lk,
                        input logic [7:0] err, input logic [7:0] wrap);
        step(1'b0, 1'b0, 1'b0, 5'd0, st, lk, 1'b0, err, wrap);
    endtask

    task automatic rst();
        step(1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        rst();
        // Lock: 0..4
        smp(5'd0, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        smp(5'd1, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        smp(5'd2, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        smp(5'd3, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        smp(5'd4, 2'd2, 1'b1, 1'b0, 8'd0, 8'd0);
        // Mismatch and relock
        smp(5'd5, 2'd2, 1'b1, 1'b0, 8'd0, 8'd0);
        smp(5'd9, 2'd1, 1'b0, 1'b1, 8'd1, 8'd0);
        smp(5'd10, 2'd1, 1'b0, 1'b0, 8'd1, 8'd0);
        smp(5'd11, 2'd1, 1'b0, 1'b0, 8'd1, 8'd0);
        smp(5'd12, 2'd1, 1'b0, 1'b0, 8'd1, 8'd0);
        smp(5'd13, 2'd2, 1'b1, 1'b0, 8'd1, 8'd0);
        idle(2'd2, 1'b1, 8'd1, 8'd0);
        // Clear with valid sample discards the sample
        step(1'b0, 1'b1, 1'b1, 5'd14, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        // Wrap
        rst();
        smp(5'd29, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        smp(5'd30, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        smp(5'd31, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        smp(5'd0, 2'd1, 1'b0, 1'b0, 8'd0, 8'd1);
        smp(5'd1, 2'd2, 1'b1, 1'b0, 8'd0, 8'd1);
        smp(5'd2, 2'd2, 1'b1, 1'b0, 8'd0, 8'd1);
        // Valid gaps and clear
        rst();
        smp(5'd0, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        idle(2'd1, 1'b0, 8'd0, 8'd0);
        idle(2'd1, 1'b0, 8'd0, 8'd0);
        idle(2'd1, 1'b0, 8'd0, 8'd0);
        smp(5'd1, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 5'd7, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        smp(5'd20, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        smp(5'd21, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        // Build err=3, wrap=2, locked, then reset with valid
        rst();
        smp(5'd30, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        smp(5'd31, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        smp(5'd0, 2'd1, 1'b0, 1'b0, 8'd0, 8'd1);
        smp(5'd1, 2'd1, 1'b0, 1'b0, 8'd0, 8'd1);
        smp(5'd2, 2'd2, 1'b1, 1'b0, 8'd0, 8'd1);
        smp(5'd10, 2'd1, 1'b0, 1'b1, 8'd1, 8'd1);
        idle(2'd1, 1'b0, 8'd1, 8'd1);
        smp(5'd11, 2'd1, 1'b0, 1'b0, 8'd1, 8'd1);
        smp(5'd20, 2'd1, 1'b0, 1'b1, 8'd2, 8'd1);
        smp(5'd25, 2'd1, 1'b0, 1'b1, 8'd3, 8'd1);
        smp(5'd26, 2'd1, 1'b0, 1'b0, 8'd3, 8'd1);
        smp(5'd27, 2'd1, 1'b0, 1'b0, 8'd3, 8'd1);
        smp(5'd28, 2'd1, 1'b0, 1'b0, 8'd3, 8'd1);
        smp(5'd29, 2'd2, 1'b1, 1'b0, 8'd3, 8'd1);
        smp(5'd30, 2'd2, 1'b1, 1'b0, 8'd3, 8'd1);
        smp(5'd31, 2'd2, 1'b1, 1'b0, 8'd3, 8'd1);
        smp(5'd0, 2'd2, 1'b1, 1'b0, 8'd3, 8'd2);
        step(1'b1, 1'b0, 1'b1, 5'd1, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        smp(5'd2, 2'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        // Saturation: 260 samples of 0
        rst();
        for (int i = 0; i < 260; i++) begin
            smp(5'd0, 2'd1, 1'b0, (i != 0),
                (i > 255) ? 8'd255 : 8'(i), 8'd0);
        end
        idle(2'd1, 1'b0, 8'd255, 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/q_seq_monitor.md
Name: q_seq_monitor

Overview:
- Downstream consumer of the 5-bit sequential counter output `q`.
- Samples `q` on a qualifier and checks that each new value equals the previous value plus STEP, modulo 2^WIDTH.
- Reports lock status, mismatch pulses, a saturating error count and a wrap-around count for LED/debug observation on the lab board.

Parameters:
WIDTH, 5, width of monitored value q_in
STEP, 1, expected increment between consecutive valid samples (modulo 2^WIDTH)
LOCK_CNT, 4, consecutive good steps required to declare lock (1..2^CNT_W-1)
CNT_W, 8, width of err_cnt and wrap_cnt

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
valid  in  1  q_in is sampled on a clk edge where valid=1
q_in  in  WIDTH  value from upstream counter stage
clear  in  1  synchronous soft clear of state and counters
locked  out  1  high while FSM is in LOCK
mismatch  out  1  one-cycle pulse after a sample that broke the sequence
err_cnt  out  CNT_W  number of mismatches, saturating at all-ones
wrap_cnt  out  CNT_W  number of correct wrap-around steps, wraps modulo 2^CNT_W
state  out  2  FSM state for debug: 0=EMPTY, 1=TRACK, 2=LOCK

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset (`reset`=1 at an edge):
  - state=EMPTY; locked=0, mismatch=0, err_cnt=0, wrap_cnt=0.
  - Internal prev=0, run=0.
  - Overrides clear and valid. Asserting reset mid-sequence drops all history at that edge.
- Priority at each edge: reset > clear > valid.
- clear=1: same effect as reset on state, counters, prev and run. A valid sample in the same cycle is discarded.
- All outputs are registered and update at the edge that samples valid. Latency is 1 clk from sample to output. No combinational input-to-output paths.
- valid=0: all registers hold. mismatch is forced to 0.
- Internal registers:
  - prev: WIDTH bits.
  - run: CNT_W bits, saturating at LOCK_CNT.
  - expected = (prev + STEP) mod 2^WIDTH, truncated to WIDTH bits.
- FSM on each valid sample:
  - EMPTY: prev<=q_in, run<=0, go to TRACK. No mismatch and no count change, because there is nothing to compare against.
  - TRACK, q_in==expected (good step):
    - run<=run+1.
    - If run+1 >= LOCK_CNT, go to LOCK; otherwise stay in TRACK.
  - LOCK, q_in==expected: stay in LOCK; run holds at LOCK_CNT.
  - TRACK or LOCK, q_in!=expected (mismatch):
    - mismatch<=1 for exactly one cycle.
    - err_cnt<=err_cnt+1, unless err_cnt is all-ones (then it holds).
    - run<=0; state goes to TRACK (resync to the new value).
  - In TRACK and LOCK, prev<=q_in on every valid sample, good or bad.
- Wrap detection:
  - Applies only on a good step where q_in < prev (unsigned).
  - Then wrap_cnt<=wrap_cnt+1, rolling over from all-ones to 0.
  - A mismatch never increments wrap_cnt.
- locked = (state==LOCK). Asserted in the cycle after the LOCK_CNT-th consecutive good step.
- Consecutive valid samples with mismatch: mismatch stays high for each such cycle, and err_cnt increments each time.
- The state encoding 3 is unreachable. If entered, the next edge forces EMPTY.

Test Plan:
- Lock:
  - Stimulus: reset 1 cycle, then valid=1 with q_in=0,1,2,3,4 on consecutive edges.
  - Response: state 1 after 0; locked=1 after sample 4; err_cnt=0; mismatch never high.
- Wrap:
  - Stimulus: after reset, q_in=29,30,31,0,1,2.
  - Response: wrap_cnt=1 one cycle after sample 0; locked=1 after sample 1; no mismatch.
- Mismatch and relock:
  - Stimulus: locked at q=4, then q_in=5,9,10,11,12,13.
  - Response: mismatch=1 for exactly one cycle after 9; err_cnt=1; locked=0 and state=1 after 9; locked=1 again after 13.
- Valid gaps and clear:
  - Stimulus: samples 0,1 separated by 3 idle cycles (valid=0).
  - Response: outputs hold during gaps; step is still good.
  - Stimulus: then clear=1 with valid=1, q_in=7.
  - Response: state=0, counters 0; the next sample q_in=20 gives no mismatch.
- Saturation:
  - Stimulus: 260 valid samples alternating q_in=0,0.
  - Response: err_cnt stops at 255; mismatch pulses every cycle after the first sample.
- Reset mid-operation:
  - Stimulus: with err_cnt=3, wrap_cnt=2 and locked=1, assert reset together with valid=1.
  - Response: all outputs 0 and state=0 at the next edge; the sample is ignored.
